// File: rtl/ssd_scan_ctrl_pkg.sv
// ssd_scan_ctrl_pkg: shared scan-controller types, constants and segment helpers
//   state_t  : scan FSM states (IDLE, BLANK, SHOW)
//   SEG_OFF  : all segments dark (active-low)
//   AN_OFF   : all anodes off (active-low)
//   hex_seg  : nibble -> {g,f,e,d,c,b,a} active-low pattern
//   lz_blank : leading-zero test for digit k of a 16-bit hex value
package ssd_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Digit k is a leading zero when it and every digit to its left are zero;
    // digit 0 never qualifies so a zero value still shows "0".
    function automatic logic lz_blank(input logic [15:0] d, input logic [1:0] k);
        return (k != 2'd0) && ((d >> {k, 2'b00}) == 16'h0);
    endfunction

endpackage

// File: rtl/ssd_scan_ctrl_hex_decode.sv
// ssd_hex_decode: combinational hex nibble to active-low 7-segment pattern
//   i_nib : hex nibble
//   o_seg : {g,f,e,d,c,b,a}, active-low
module ssd_hex_decode
    import ssd_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = hex_seg(i_nib);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: 4-digit multiplexed 7-segment scan with blanking and double-buffered data
//   dclk          : clock
//   rst           : asynchronous active-high reset
//   i_enable      : 1 = scan, 0 = dark and idle
//   i_upd_valid   : update request; accepted when o_upd_ready is high
//   o_upd_ready   : pending buffer empty
//   i_upd_data    : four hex nibbles, [3:0] = rightmost digit
//   i_upd_dp      : decimal points per digit, 1 = lit
//   i_upd_lzb     : leading-zero blanking for this update
//   o_an          : anodes, active-low
//   o_seg         : segments {g,f,e,d,c,b,a}, active-low
//   o_dp          : decimal point, active-low
//   o_frame_done  : one-cycle pulse after digit 3 finishes its dwell
module ssd_scan_ctrl
    import ssd_scan_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        dclk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_upd_valid,
    output logic        o_upd_ready,
    input  logic [15:0] i_upd_data,
    input  logic [3:0]  i_upd_dp,
    input  logic        i_upd_lzb,
    output logic [3:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic        o_frame_done
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int W    = $clog2(MAXC + 1);
    localparam logic [W-1:0] C_DWELL = W'(DWELL_CYCLES - 1);
    // With no blank phase, each digit boundary goes straight into the next dwell.
    localparam state_t       START_ST = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
    localparam logic [W-1:0] C_START  = W'((BLANK_CYCLES == 0) ? DWELL_CYCLES - 1 : BLANK_CYCLES - 1);

    state_t       r_state;
    logic [1:0]   r_idx;
    logic [W-1:0] r_cnt;
    logic [15:0]  r_act_data, r_pnd_data;
    logic [3:0]   r_act_dp, r_pnd_dp;
    logic         r_act_lzb, r_pnd_lzb, r_pnd_full;

    state_t       w_nxt_state;
    logic [1:0]   w_nxt_idx;
    logic [W-1:0] w_nxt_cnt;
    logic         w_end, w_frame, w_commit, w_accept, w_show;
    logic [15:0]  w_nxt_data;
    logic [3:0]   w_nxt_dp, w_nib;
    logic         w_nxt_lzb;
    logic [6:0]   w_seg;

    assign w_end    = (r_cnt == '0);
    assign w_frame  = i_enable && (r_state == ST_SHOW) && (r_idx == 2'd3) && w_end;
    // Commits happen only at a frame boundary or while idle, so a frame never mixes buffers.
    assign w_commit = r_pnd_full && ((r_state == ST_IDLE) || w_frame);
    assign w_accept = i_upd_valid && !r_pnd_full;
    assign o_upd_ready = !r_pnd_full;

    always_comb begin
        w_nxt_state = ST_IDLE;
        w_nxt_idx   = 2'd0;
        w_nxt_cnt   = '0;
        if (i_enable) begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_state = START_ST;
                    w_nxt_cnt   = C_START;
                end
                ST_BLANK: begin
                    w_nxt_state = w_end ? ST_SHOW : ST_BLANK;
                    w_nxt_idx   = r_idx;
                    w_nxt_cnt   = w_end ? C_DWELL : r_cnt - W'(1);
                end
                default: begin
                    w_nxt_state = w_end ? START_ST : ST_SHOW;
                    w_nxt_idx   = w_end ? r_idx + 2'd1 : r_idx;
                    w_nxt_cnt   = w_end ? C_START : r_cnt - W'(1);
                end
            endcase
        end
    end

    // Outputs are registered from next-cycle values so they move on the same edge
    // as state/idx, including a commit immediately followed by digit 0.
    assign w_nxt_data = w_commit ? r_pnd_data : r_act_data;
    assign w_nxt_dp   = w_commit ? r_pnd_dp   : r_act_dp;
    assign w_nxt_lzb  = w_commit ? r_pnd_lzb  : r_act_lzb;
    assign w_nib      = 4'(w_nxt_data >> {w_nxt_idx, 2'b00});
    assign w_show     = (w_nxt_state == ST_SHOW);

    ssd_hex_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= 2'd0;
            r_cnt        <= '0;
            r_act_data   <= 16'h0;
            r_act_dp     <= 4'h0;
            r_act_lzb    <= 1'b0;
            r_pnd_data   <= 16'h0;
            r_pnd_dp     <= 4'h0;
            r_pnd_lzb    <= 1'b0;
            r_pnd_full   <= 1'b0;
            o_an         <= AN_OFF;
            o_seg        <= SEG_OFF;
            o_dp         <= 1'b1;
            o_frame_done <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_idx        <= w_nxt_idx;
            r_cnt        <= w_nxt_cnt;
            r_act_data   <= w_nxt_data;
            r_act_dp     <= w_nxt_dp;
            r_act_lzb    <= w_nxt_lzb;
            if (w_commit) begin
                r_pnd_full <= 1'b0;
            end else if (w_accept) begin
                r_pnd_data <= i_upd_data;
                r_pnd_dp   <= i_upd_dp;
                r_pnd_lzb  <= i_upd_lzb;
                r_pnd_full <= 1'b1;
            end
            o_an         <= w_show ? ~(4'b0001 << w_nxt_idx) : AN_OFF;
            o_seg        <= (w_show && !(w_nxt_lzb && lz_blank(w_nxt_data, w_nxt_idx))) ? w_seg : SEG_OFF;
            o_dp         <= ~(w_show & w_nxt_dp[w_nxt_idx]);
            o_frame_done <= w_frame;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed bench with a frame-position model for two blanking settings
module tb_ssd_scan_ctrl;

    localparam int DW = 4;
    localparam int BLN [2] = '{2, 0};
    localparam logic [6:0] HX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        dclk = 1'b0;
    logic        rst;
    logic        en;
    logic        vld [2];
    logic [15:0] data;
    logic [3:0]  dpi;
    logic        lzb;
    logic        rdy [2];
    logic [3:0]  an_w [2];
    logic [6:0]  seg_w [2];
    logic        dp_w [2];
    logic        fd_w [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 dclk = ~dclk;

    ssd_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(2)) dut (
        .dclk(dclk), .rst(rst), .i_enable(en), .i_upd_valid(vld[0]), .o_upd_ready(rdy[0]),
        .i_upd_data(data), .i_upd_dp(dpi), .i_upd_lzb(lzb),
        .o_an(an_w[0]), .o_seg(seg_w[0]), .o_dp(dp_w[0]), .o_frame_done(fd_w[0])
    );

    ssd_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(0)) dut0 (
        .dclk(dclk), .rst(rst), .i_enable(en), .i_upd_valid(vld[1]), .o_upd_ready(rdy[1]),
        .i_upd_data(data), .i_upd_dp(dpi), .i_upd_lzb(lzb),
        .o_an(an_w[1]), .o_seg(seg_w[1]), .o_dp(dp_w[1]), .o_frame_done(fd_w[1])
    );

    // Model: position within a frame of 4 x (blank + dwell) cycles since the scan started.
    bit          m_run  [2];
    int          m_t    [2];
    logic [15:0] m_ad   [2];
    logic [3:0]  m_adp  [2];
    logic        m_alz  [2];
    bit          m_pf   [2];
    logic [15:0] m_pd   [2];
    logic [3:0]  m_pdp  [2];
    logic        m_plz  [2];
    bit          m_fd   [2];

    always @(posedge dclk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                m_run[m] = 0; m_t[m] = 0; m_ad[m] = 0; m_adp[m] = 0; m_alz[m] = 0;
                m_pf[m] = 0; m_pd[m] = 0; m_pdp[m] = 0; m_plz[m] = 0; m_fd[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                int  fl;
                bit  acc, fe, cm;
                fl  = 4 * (BLN[m] + DW);
                acc = vld[m] && !m_pf[m];
                fe  = m_run[m] && en && (m_t[m] % fl) == fl - 1;
                cm  = m_pf[m] && (!m_run[m] || fe);
                m_fd[m] = fe;
                if (cm) begin
                    m_ad[m] = m_pd[m]; m_adp[m] = m_pdp[m]; m_alz[m] = m_plz[m]; m_pf[m] = 0;
                end
                if (acc) begin
                    m_pd[m] = data; m_pdp[m] = dpi; m_plz[m] = lzb; m_pf[m] = 1;
                end
                m_t[m]   = (en && m_run[m]) ? m_t[m] + 1 : 0;
                m_run[m] = en;
            end
        end
    end

    task automatic exp_out(input int m, output logic [3:0] a, output logic [6:0] s, output logic d);
        int p, pos, k;
        logic [15:0] sh;
        p   = BLN[m] + DW;
        pos = m_t[m] % (4 * p);
        k   = pos / p;
        a = 4'hF; s = 7'h7F; d = 1'b1;
        if (m_run[m] && (pos % p) >= BLN[m]) begin
            sh = m_ad[m] >> (4 * k);
            a  = 4'hF ^ (4'h1 << k);
            s  = (m_alz[m] && k != 0 && sh == 16'h0) ? 7'h7F : HX[sh[3:0]];
            d  = !m_adp[m][k];
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge dclk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                logic [3:0] ea;
                logic [6:0] es;
                logic       ed;
                exp_out(m, ea, es, ed);
                chk($sformatf("model_an[%0d]", m),    16'(an_w[m]),  16'(ea));
                chk($sformatf("model_seg[%0d]", m),   16'(seg_w[m]), 16'(es));
                chk($sformatf("model_dp[%0d]", m),    16'(dp_w[m]),  16'(ed));
                chk($sformatf("model_ready[%0d]", m), 16'(rdy[m]),   16'(!m_pf[m]));
                chk($sformatf("model_fd[%0d]", m),    16'(fd_w[m]),  16'(m_fd[m]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge dclk);
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting, expected event within bound", nm);
    endtask

    task automatic upd(input int m, input logic [15:0] d, input logic [3:0] p, input logic z);
        int w = 0;
        while (!rdy[m] && w < 100) begin
            @(negedge dclk);
            w++;
        end
        if (!rdy[m]) timeout("upd_ready_wait");
        else begin
            data = d; dpi = p; lzb = z; vld[m] = 1'b1;
            @(negedge dclk);
            vld[m] = 1'b0;
        end
    endtask

    task automatic wait_an(input string nm, input logic [3:0] a, output bit ok);
        int w = 0;
        while (an_w[0] !== a && w < 80) begin
            @(negedge dclk);
            w++;
        end
        ok = (an_w[0] === a);
        if (!ok) timeout(nm);
    endtask

    task automatic look(input string nm, input logic [3:0] a, input logic [6:0] s, input logic d);
        bit ok;
        wait_an(nm, a, ok);
        if (ok) begin
            chk({nm, "_seg"}, 16'(seg_w[0]), 16'(s));
            chk({nm, "_dp"},  16'(dp_w[0]),  16'(d));
        end
    endtask

    task automatic wait_fd(input string nm);
        int w = 0;
        while (!fd_w[0] && w < 100) begin
            @(negedge dclk);
            w++;
        end
        if (!fd_w[0]) timeout(nm);
        else @(negedge dclk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  ok;
        rst = 1'b1; en = 1'b0; vld[0] = 1'b0; vld[1] = 1'b0; data = 16'h0; dpi = 4'h0; lzb = 1'b0;
        tick(3);
        rst = 1'b0;
        chk_en = 1'b1;
        tick(10);
        chk("rst_an", 16'(an_w[0]), 16'hF);
        chk("rst_seg", 16'(seg_w[0]), 16'h7F);
        chk("rst_dp", 16'(dp_w[0]), 16'h1);
        chk("rst_ready", 16'(rdy[0]), 16'h1);
        upd(0, 16'h1234, 4'b0101, 1'b0);
        chk("idle_acc_ready", 16'(rdy[0]), 16'h0);
        tick(1);
        chk("idle_commit_ready", 16'(rdy[0]), 16'h1);
        upd(1, 16'h1234, 4'b0101, 1'b0);
        tick(1);
        en = 1'b1;
        tick(1);
        chk("first_blank_an", 16'(an_w[0]), 16'hF);
        tick(2);
        chk("d0_an", 16'(an_w[0]), 16'hE);
        chk("d0_seg", 16'(seg_w[0]), 16'h19);
        chk("d0_dp", 16'(dp_w[0]), 16'h0);
        tick(6);
        chk("d1_an", 16'(an_w[0]), 16'hD);
        chk("d1_seg", 16'(seg_w[0]), 16'h30);
        chk("d1_dp", 16'(dp_w[0]), 16'h1);
        tick(15);
        chk("d3_an", 16'(an_w[0]), 16'h7);
        chk("d3_seg", 16'(seg_w[0]), 16'h79);
        chk("d3_fd_low", 16'(fd_w[0]), 16'h0);
        tick(1);
        chk("frame_done", 16'(fd_w[0]), 16'h1);
        chk("frame_blank_an", 16'(an_w[0]), 16'hF);
        upd(0, 16'hABCD, 4'h0, 1'b0);
        chk("mid_acc_ready", 16'(rdy[0]), 16'h0);
        tick(19);
        chk("old_d3_an", 16'(an_w[0]), 16'h7);
        chk("old_d3_seg", 16'(seg_w[0]), 16'h79);
        tick(4);
        chk("commit_fd", 16'(fd_w[0]), 16'h1);
        chk("commit_ready", 16'(rdy[0]), 16'h1);
        tick(2);
        chk("new_d0_an", 16'(an_w[0]), 16'hE);
        chk("new_d0_seg", 16'(seg_w[0]), 16'h21);
        upd(0, 16'h0050, 4'h0, 1'b1);
        wait_fd("lzb_commit");
        look("lzb_d0", 4'hE, 7'h40, 1'b1);
        look("lzb_d1", 4'hD, 7'h12, 1'b1);
        look("lzb_d2", 4'hB, 7'h7F, 1'b1);
        look("lzb_d3", 4'h7, 7'h7F, 1'b1);
        upd(0, 16'h0000, 4'h0, 1'b1);
        wait_fd("zero_commit");
        look("zero_d0", 4'hE, 7'h40, 1'b1);
        look("zero_d1", 4'hD, 7'h7F, 1'b1);
        look("zero_d2", 4'hB, 7'h7F, 1'b1);
        look("zero_d3", 4'h7, 7'h7F, 1'b1);
        upd(0, 16'h8888, 4'b0101, 1'b0);
        wait_fd("dp_commit");
        look("dp_d0", 4'hE, 7'h00, 1'b0);
        look("dp_d1", 4'hD, 7'h00, 1'b1);
        look("dp_d2", 4'hB, 7'h00, 1'b0);
        look("dp_d3", 4'h7, 7'h00, 1'b1);
        wait_an("drop_find", 4'hB, ok);
        en = 1'b0;
        tick(1);
        chk("drop_an", 16'(an_w[0]), 16'hF);
        chk("drop_seg", 16'(seg_w[0]), 16'h7F);
        tick(3);
        en = 1'b1;
        cnt = 0;
        while (an_w[0] === 4'hF && cnt < 20) begin
            @(negedge dclk);
            cnt++;
        end
        chk("restart_an", 16'(an_w[0]), 16'hE);
        chk("restart_delay", 16'(cnt), 16'd3);
        upd(0, 16'h5678, 4'hF, 1'b0);
        chk("arst_pend_full", 16'(rdy[0]), 16'h0);
        wait_an("arst_find_lit", 4'hD, ok);
        cnt = 0;
        while (an_w[0] !== 4'hF && cnt < 20) begin
            @(negedge dclk);
            cnt++;
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", 16'(rdy[0]), 16'h1);
        chk("arst_an", 16'(an_w[0]), 16'hF);
        chk("arst_fd", 16'(fd_w[0]), 16'h0);
        @(negedge dclk);
        rst = 1'b0;
        look("arst_cleared_d0", 4'hE, 7'h40, 1'b1);
        cnt = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge dclk);
            if (an_w[1] === 4'hF) cnt++;
        end
        chk("noblank_dark_cycles", 16'(cnt), 16'd0);
        en = 1'b0;
        tick(5);
        chk("end_an", 16'(an_w[0]), 16'hF);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
